// File: rtl/sha256_pkg.sv
// Shared SHA-256 types and constants for the compression controller
// and datapath.
package sha256_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    ROUND,
    FINAL,
    DONE
  } state_t;

  localparam int SHA256_ROUNDS    = 64;
  localparam int SHA256_MSG_WORDS = 16;

  localparam logic [31:0] SHA256_H0 [8] = '{
    32'h6a09e667, 32'hbb67ae85,
    32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c,
    32'h1f83d9ab, 32'h5be0cd19
  };

endpackage

// File: rtl/sha256_round_counter.sv
// Phase-within-round counter and round index with terminal-count
// flags for the SHA-256 round sequencer.
module sha256_round_counter
  import sha256_pkg::*;
#(
  parameter int ROUND_CYCLES = 2,
  parameter int NUM_ROUNDS   = SHA256_ROUNDS
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       en,
  input  logic       clear,
  output logic       ph_pre,
  output logic       ph_last,
  output logic [5:0] round_idx,
  output logic       round_last
);

  logic [1:0] ph;

  assign ph_pre     = (ph == 2'(ROUND_CYCLES - 2));
  assign ph_last    = (ph == 2'(ROUND_CYCLES - 1));
  assign round_last = (round_idx == 6'(NUM_ROUNDS - 1));

  // Index wraps to 0 on leaving the last round, so it idles at 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ph        <= '0;
      round_idx <= '0;
    end else if (clear) begin
      ph        <= '0;
      round_idx <= '0;
    end else if (en) begin
      if (ph_last) begin
        ph        <= '0;
        round_idx <= round_last ? 6'd0 : round_idx + 6'd1;
      end else begin
        ph <= ph + 2'd1;
      end
    end
  end

endmodule

// File: rtl/sha256_round_ctrl.sv
// SHA-256 compression sequencer: issues hash/working-register enables
// and round indices; holds no datapath state.
module sha256_round_ctrl
  import sha256_pkg::*;
#(
  parameter int ROUND_CYCLES = 2,
  parameter int NUM_ROUNDS   = SHA256_ROUNDS
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       first_block,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       hash_init,
  output logic       work_load,
  output logic       w_sel_msg,
  output logic [5:0] round_idx,
  output logic [3:0] msg_addr,
  output logic       calc_en,
  output logic       round_en,
  output logic       hash_add
);

  state_t     state;
  logic       ph_pre;
  logic       ph_last;
  logic       round_last;
  logic       cnt_en;
  logic       cnt_clr;
  logic [6:0] nxt_idx;
  logic       nxt_msg;

  assign cnt_en  = (state == ROUND) && !abort;
  assign cnt_clr = abort;
  assign nxt_idx = {1'b0, round_idx} + {6'd0, ph_last};
  assign nxt_msg = (nxt_idx < 7'(SHA256_MSG_WORDS));

  assign msg_addr = round_idx[3:0];

  sha256_round_counter #(
    .ROUND_CYCLES(ROUND_CYCLES),
    .NUM_ROUNDS  (NUM_ROUNDS)
  ) u_cnt (
    .clock     (clock),
    .reset     (reset),
    .en        (cnt_en),
    .clear     (cnt_clr),
    .ph_pre    (ph_pre),
    .ph_last   (ph_last),
    .round_idx (round_idx),
    .round_last(round_last)
  );

  // Outputs are registered from next-cycle counter values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      hash_init <= 1'b0;
      work_load <= 1'b0;
      w_sel_msg <= 1'b0;
      calc_en   <= 1'b0;
      round_en  <= 1'b0;
      hash_add  <= 1'b0;
    end else begin
      hash_init <= 1'b0;
      work_load <= 1'b0;
      hash_add  <= 1'b0;
      done      <= 1'b0;
      if (abort && state != IDLE) begin
        state     <= IDLE;
        busy      <= 1'b0;
        calc_en   <= 1'b0;
        round_en  <= 1'b0;
        w_sel_msg <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              state     <= INIT;
              busy      <= 1'b1;
              hash_init <= first_block;
            end
          end
          INIT: begin
            state     <= ROUND;
            work_load <= 1'b1;
            calc_en   <= 1'b1;
            w_sel_msg <= 1'b1;
          end
          ROUND: begin
            if (ph_last && round_last) begin
              state     <= FINAL;
              hash_add  <= 1'b1;
              calc_en   <= 1'b0;
              round_en  <= 1'b0;
              w_sel_msg <= 1'b0;
            end else begin
              calc_en   <= ph_last;
              round_en  <= ph_pre;
              w_sel_msg <= nxt_msg;
            end
          end
          FINAL: begin
            state <= DONE;
            done  <= 1'b1;
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Scoreboard bench for sha256_round_ctrl: default instance plus a
// short ROUND_CYCLES=3 / NUM_ROUNDS=20 instance.
module tb_sha256_round_ctrl;

  typedef struct packed {
    int kind;
    int cyc;
  } ev_t;

  typedef struct packed {
    int         cyc;
    logic [5:0] idx;
    logic       ws;
    logic [3:0] ma;
  } tr_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic first_block = 1'b0;
  logic abort = 1'b0;

  logic a_busy, a_done, a_hinit, a_wload, a_wsel;
  logic a_calc, a_ren, a_hadd;
  logic [5:0] a_idx;
  logic [3:0] a_ma;
  logic b_busy, b_done, b_hinit, b_wload, b_wsel;
  logic b_calc, b_ren, b_hadd;
  logic [5:0] b_idx;
  logic [3:0] b_ma;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  ev_t expq[$];
  ev_t obsq[$];
  int  renq[$];
  tr_t trq[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  sha256_round_ctrl u_a (
    .clock(clock), .reset(reset),
    .start(start_a), .first_block(first_block),
    .abort(abort), .busy(a_busy), .done(a_done),
    .hash_init(a_hinit), .work_load(a_wload),
    .w_sel_msg(a_wsel), .round_idx(a_idx),
    .msg_addr(a_ma), .calc_en(a_calc),
    .round_en(a_ren), .hash_add(a_hadd)
  );

  sha256_round_ctrl #(
    .ROUND_CYCLES(3), .NUM_ROUNDS(20)
  ) u_b (
    .clock(clock), .reset(reset),
    .start(start_b), .first_block(first_block),
    .abort(abort), .busy(b_busy), .done(b_done),
    .hash_init(b_hinit), .work_load(b_wload),
    .w_sel_msg(b_wsel), .round_idx(b_idx),
    .msg_addr(b_ma), .calc_en(b_calc),
    .round_en(b_ren), .hash_add(b_hadd)
  );

  wire [17:0] a_all = {a_busy, a_done, a_hinit, a_wload,
    a_wsel, a_idx, a_ma, a_calc, a_ren, a_hadd};
  wire [17:0] b_all = {b_busy, b_done, b_hinit, b_wload,
    b_wsel, b_idx, b_ma, b_calc, b_ren, b_hadd};

  function automatic ev_t mk(input int k, input int c);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    return e;
  endfunction

  task automatic clear_q();
    expq.delete();
    obsq.delete();
    renq.delete();
    trq.delete();
  endtask

  // Observation only: records pulses, round_en cycles, round traces.
  task automatic observe(input bit use_b, input int max_cyc,
                         input bit stop_done, input int stop_round,
                         output bit hit, output int busy_n);
    logic bz, dn, hi, wl, ws, ce, re, ha;
    logic [5:0] ix;
    logic [3:0] ma;
    tr_t t;
    hit = 1'b0;
    busy_n = 0;
    for (int n = 0; n < max_cyc; n++) begin
      @(negedge clock);
      {bz, dn, hi, wl, ws, ix, ma, ce, re, ha} =
        use_b ? b_all : a_all;
      if (hi) obsq.push_back(mk(0, cyc));
      if (wl) obsq.push_back(mk(1, cyc));
      if (ha) obsq.push_back(mk(2, cyc));
      if (dn) obsq.push_back(mk(3, cyc));
      if (bz) busy_n++;
      if (re) renq.push_back(cyc);
      if (ce) begin
        t.cyc = cyc;
        t.idx = ix;
        t.ws  = ws;
        t.ma  = ma;
        trq.push_back(t);
      end
      if (stop_done && dn) begin
        hit = 1'b1;
        break;
      end
      if (stop_round >= 0 && ce && int'(ix) == stop_round) begin
        hit = 1'b1;
        break;
      end
    end
  endtask

  task automatic launch(input bit use_b, input bit fb,
                        output int acc);
    @(negedge clock);
    if (use_b) start_b = 1'b1;
    else start_a = 1'b1;
    first_block = fb;
    acc = cyc + 1;
    @(posedge clock);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (a_all !== 18'd0) begin
      errors++;
      $display("FAIL reset_a: got %h want 0", a_all);
    end
    checks++;
    if (b_all !== 18'd0) begin
      errors++;
      $display("FAIL reset_b: got %h want 0", b_all);
    end
  endtask

  task automatic test_full_block();
    int acc, bn;
    bit hit;
    ev_t e, o;
    tr_t t, w;
    clear_q();
    launch(1'b0, 1'b1, acc);
    expq.push_back(mk(0, acc));
    expq.push_back(mk(1, acc + 1));
    expq.push_back(mk(2, acc + 129));
    expq.push_back(mk(3, acc + 130));
    observe(1'b0, 300, 1'b1, -1, hit, bn);
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL full_timeout: done not seen");
    end
    while (expq.size() > 0) begin
      e = expq.pop_front();
      checks++;
      if (obsq.size() == 0) begin
        errors++;
        $display("FAIL full_ev: missing kind %0d cyc %0d",
                 e.kind, e.cyc);
      end else begin
        o = obsq.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL full_ev: got %0d@%0d want %0d@%0d",
                   o.kind, o.cyc, e.kind, e.cyc);
        end
      end
    end
    checks++;
    if (obsq.size() != 0) begin
      errors++;
      $display("FAIL full_extra: %0d extra pulses", obsq.size());
    end
    checks++;
    if (bn != 131) begin
      errors++;
      $display("FAIL full_busy: got %0d want 131", bn);
    end
    checks++;
    if (renq.size() != 64 || trq.size() != 64) begin
      errors++;
      $display("FAIL full_rounds: ren %0d calc %0d want 64",
               renq.size(), trq.size());
    end
    for (int i = 0; i < 64 && i < renq.size(); i++) begin
      checks++;
      if (renq[i] != acc + 2 + 2 * i) begin
        errors++;
        $display("FAIL full_ren%0d: got %0d want %0d",
                 i, renq[i], acc + 2 + 2 * i);
      end
    end
    for (int i = 0; i < 64 && i < trq.size(); i++) begin
      t = trq[i];
      w.cyc = acc + 1 + 2 * i;
      w.idx = 6'(i);
      w.ws  = (i < 16);
      w.ma  = 4'(i);
      if (i >= 16) t.ma = w.ma;
      checks++;
      if (t !== w) begin
        errors++;
        $display("FAIL full_trace%0d: got %h want %h", i, t, w);
      end
    end
    checks++;
    if (a_idx !== 6'd0) begin
      errors++;
      $display("FAIL full_idx_wrap: got %0d want 0", a_idx);
    end
    @(negedge clock);
    checks++;
    if (a_busy !== 1'b0) begin
      errors++;
      $display("FAIL full_busy_end: got %b want 0", a_busy);
    end
  endtask

  task automatic test_back_to_back();
    int acc, acc2, b1, b2, b3;
    bit h1, h2;
    ev_t e, o;
    clear_q();
    @(negedge clock);
    start_a = 1'b1;
    first_block = 1'b1;
    acc = cyc + 1;
    @(posedge clock);
    #1;
    first_block = 1'b0;
    acc2 = acc + 132;
    expq.push_back(mk(0, acc));
    expq.push_back(mk(1, acc + 1));
    expq.push_back(mk(2, acc + 129));
    expq.push_back(mk(3, acc + 130));
    expq.push_back(mk(1, acc2 + 1));
    expq.push_back(mk(2, acc2 + 129));
    expq.push_back(mk(3, acc2 + 130));
    observe(1'b0, 300, 1'b1, -1, h1, b1);
    observe(1'b0, 300, 1'b1, -1, h2, b2);
    start_a = 1'b0;
    observe(1'b0, 6, 1'b0, -1, h1, b3);
    checks++;
    if (!h2) begin
      errors++;
      $display("FAIL b2b_timeout: second done not seen");
    end
    while (expq.size() > 0) begin
      e = expq.pop_front();
      checks++;
      if (obsq.size() == 0) begin
        errors++;
        $display("FAIL b2b_ev: missing kind %0d cyc %0d",
                 e.kind, e.cyc);
      end else begin
        o = obsq.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL b2b_ev: got %0d@%0d want %0d@%0d",
                   o.kind, o.cyc, e.kind, e.cyc);
        end
      end
    end
    checks++;
    if (obsq.size() != 0) begin
      errors++;
      $display("FAIL b2b_extra: %0d extra pulses", obsq.size());
    end
    checks++;
    if (b1 + b2 + b3 != 262) begin
      errors++;
      $display("FAIL b2b_busy: got %0d want 262", b1 + b2 + b3);
    end
  endtask

  task automatic test_abort();
    int acc, bn;
    bit hit;
    ev_t e, o;
    clear_q();
    launch(1'b0, 1'b1, acc);
    expq.push_back(mk(0, acc));
    expq.push_back(mk(1, acc + 1));
    observe(1'b0, 200, 1'b0, 40, hit, bn);
    checks++;
    if (!hit || cyc != acc + 81) begin
      errors++;
      $display("FAIL abort_r40: hit %0b cyc %0d want %0d",
               hit, cyc, acc + 81);
    end
    abort = 1'b1;
    @(posedge clock);
    #1;
    abort = 1'b0;
    checks++;
    if (a_all !== 18'd0) begin
      errors++;
      $display("FAIL abort_idle: got %h want 0", a_all);
    end
    observe(1'b0, 150, 1'b0, -1, hit, bn);
    while (expq.size() > 0) begin
      e = expq.pop_front();
      checks++;
      if (obsq.size() == 0) begin
        errors++;
        $display("FAIL abort_ev: missing kind %0d cyc %0d",
                 e.kind, e.cyc);
      end else begin
        o = obsq.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL abort_ev: got %0d@%0d want %0d@%0d",
                   o.kind, o.cyc, e.kind, e.cyc);
        end
      end
    end
    checks++;
    if (obsq.size() != 0 || bn != 0) begin
      errors++;
      $display("FAIL abort_quiet: pulses %0d busy %0d want 0 0",
               obsq.size(), bn);
    end
    clear_q();
    launch(1'b0, 1'b1, acc);
    observe(1'b0, 300, 1'b1, -1, hit, bn);
    checks++;
    if (!hit || cyc != acc + 130 || bn != 131) begin
      errors++;
      $display("FAIL abort_rerun: done@%0d busy %0d want %0d 131",
               cyc, bn, acc + 130);
    end
  endtask

  task automatic test_async_reset();
    int acc, bn;
    bit hit;
    ev_t e, o;
    clear_q();
    launch(1'b0, 1'b1, acc);
    observe(1'b0, 200, 1'b0, 10, hit, bn);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (a_all !== 18'd0) begin
      errors++;
      $display("FAIL areset_now: got %h want 0", a_all);
    end
    @(negedge clock);
    checks++;
    if (a_all !== 18'd0) begin
      errors++;
      $display("FAIL areset_hold: got %h want 0", a_all);
    end
    reset = 1'b1;
    clear_q();
    launch(1'b0, 1'b1, acc);
    expq.push_back(mk(0, acc));
    expq.push_back(mk(1, acc + 1));
    expq.push_back(mk(2, acc + 129));
    expq.push_back(mk(3, acc + 130));
    observe(1'b0, 300, 1'b1, -1, hit, bn);
    while (expq.size() > 0) begin
      e = expq.pop_front();
      checks++;
      if (obsq.size() == 0) begin
        errors++;
        $display("FAIL areset_ev: missing kind %0d cyc %0d",
                 e.kind, e.cyc);
      end else begin
        o = obsq.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL areset_ev: got %0d@%0d want %0d@%0d",
                   o.kind, o.cyc, e.kind, e.cyc);
        end
      end
    end
    checks++;
    if (bn != 131) begin
      errors++;
      $display("FAIL areset_busy: got %0d want 131", bn);
    end
  endtask

  task automatic test_short_params();
    int acc, bn;
    bit hit;
    ev_t e, o;
    clear_q();
    launch(1'b1, 1'b1, acc);
    expq.push_back(mk(0, acc));
    expq.push_back(mk(1, acc + 1));
    expq.push_back(mk(2, acc + 61));
    expq.push_back(mk(3, acc + 62));
    observe(1'b1, 150, 1'b1, -1, hit, bn);
    while (expq.size() > 0) begin
      e = expq.pop_front();
      checks++;
      if (obsq.size() == 0) begin
        errors++;
        $display("FAIL short_ev: missing kind %0d cyc %0d",
                 e.kind, e.cyc);
      end else begin
        o = obsq.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL short_ev: got %0d@%0d want %0d@%0d",
                   o.kind, o.cyc, e.kind, e.cyc);
        end
      end
    end
    checks++;
    if (bn != 63 || renq.size() != 20 || trq.size() != 20) begin
      errors++;
      $display("FAIL short_count: busy %0d ren %0d calc %0d",
               bn, renq.size(), trq.size());
    end
    for (int i = 0; i < 20 && i < renq.size()
         && i < trq.size(); i++) begin
      checks++;
      if (trq[i].cyc != acc + 1 + 3 * i ||
          renq[i] != trq[i].cyc + 2) begin
        errors++;
        $display("FAIL short_r%0d: calc %0d ren %0d want %0d %0d",
                 i, trq[i].cyc, renq[i], acc + 1 + 3 * i,
                 acc + 3 + 3 * i);
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clock);
    test_reset();
    reset = 1'b1;
    test_full_block();
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_short_params();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
